ifu_miss_handler: RTL and testbench

Line-fill engine between the IFU instruction cache and the memory bus. It accepts a miss request (tag plus level valid) from the cache and issues a single read request for the line address. It then collects the line as a burst of narrower beats and returns the assembled line with its tag as a one-cycle response pulse, which the cache uses for insertion. One miss is in flight at a time; a cooldown cycle prevents re-issuing a miss the cache has just filled.

---
 rtl/ifu_miss_handler.sv | 165 ++++++++++++++++
 tb/tb_ifu_miss_handler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_miss_handler.sv
// ifu_miss_handler
//   Line-fill engine that sits between the IFU instruction cache and the memory bus.
//   It services one miss at a time, in five steps:
//     1. Latch the missing tag.
//     2. Issue one line-aligned read request.
//     3. Collect NUM_BEATS data beats into a line. Beat 0 is the least significant.
//     4. Return the line and its tag with a single-cycle valid pulse.
//     5. Spend one cooldown cycle so that the cache can update its hit status
//        before a new miss is accepted.
//   Every output is decoded from registers, so no input reaches an output combinationally.
//
// Ports
//   Clock                  : clock; all state changes on the rising edge
//   Rst                    : asynchronous reset, active-low
//   mem_reqTagIn           : tag of the missing line
//   mem_reqTagValidIn      : level signal, high while the cache misses
//   mem_rspTagOut          : tag of the returned line (holds its value outside the pulse)
//   mem_rspInsLineOut      : assembled line (holds its value outside the pulse)
//   mem_rspInsLineValidOut : one-cycle pulse that qualifies the tag and line
//   bus_reqValidOut        : read request valid
//   bus_reqAddrOut         : line-aligned read address
//   bus_reqReadyIn         : bus accepts the request in this cycle
//   bus_rspValidIn         : data beat valid
//   bus_rspDataIn          : data beat
//   busyOut                : engine is not idle
//   missCountOut           : count of issued fills; saturates at 0xFFFF
module ifu_miss_handler #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH,
  parameter int LINE_WIDTH   = 128,
  parameter int BEAT_WIDTH   = 32,
  parameter int NUM_BEATS    = LINE_WIDTH / BEAT_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [TAG_WIDTH-1:0]  mem_reqTagIn,
  input  logic                  mem_reqTagValidIn,
  output logic [TAG_WIDTH-1:0]  mem_rspTagOut,
  output logic [LINE_WIDTH-1:0] mem_rspInsLineOut,
  output logic                  mem_rspInsLineValidOut,
  output logic                  bus_reqValidOut,
  output logic [ADDR_WIDTH-1:0] bus_reqAddrOut,
  input  logic                  bus_reqReadyIn,
  input  logic                  bus_rspValidIn,
  input  logic [BEAT_WIDTH-1:0] bus_rspDataIn,
  output logic                  busyOut,
  output logic [15:0]           missCountOut
);

  localparam int CNT_WIDTH = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    DATA = 3'd2,
    RESP = 3'd3,
    COOL = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0] line_merged;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [15:0]           miss_cnt;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;
  logic [LINE_WIDTH-1:0] rsp_line_q;
  logic                  accept;
  logic                  beat;
  logic                  last_beat;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept    = (state == IDLE) && mem_reqTagValidIn;
  assign beat      = (state == DATA) && bus_rspValidIn;
  assign last_beat = beat && (cnt == CNT_WIDTH'(NUM_BEATS - 1));

  // Current line with the incoming beat merged into its slot.
  // Constant slice indices keep the select simple for synthesis.
  always_comb begin
    line_merged = line_q;
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (cnt == CNT_WIDTH'(b)) begin
        line_merged[b*BEAT_WIDTH +: BEAT_WIDTH] = bus_rspDataIn;
      end
    end
  end

  // State register
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_reqTagValidIn) state_next = REQ;
      REQ:     if (bus_reqReadyIn)    state_next = DATA;
      DATA:    if (last_beat)         state_next = RESP;
      RESP:    state_next = COOL;
      // COOL ignores the miss input while the cache hit status settles.
      COOL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and registered datapath
  always_comb begin
    bus_reqValidOut        = 1'b0;
    bus_reqAddrOut         = '0;
    mem_rspInsLineValidOut = 1'b0;
    busyOut                = (state != IDLE);
    case (state)
      REQ: begin
        bus_reqValidOut = 1'b1;
        bus_reqAddrOut  = {tag_q, {OFFSET_WIDTH{1'b0}}};
      end
      RESP:    mem_rspInsLineValidOut = 1'b1;
      default: ;
    endcase
  end

  assign mem_rspTagOut     = rsp_tag_q;
  assign mem_rspInsLineOut = rsp_line_q;
  assign missCountOut      = miss_cnt;

  // Datapath: tag latch, beat assembly and response capture.
  // The response registers load only on the final beat. This lets them hold
  // the last line and tag while the next fill assembles in line_q.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      tag_q      <= '0;
      line_q     <= '0;
      cnt        <= '0;
      miss_cnt   <= '0;
      rsp_tag_q  <= '0;
      rsp_line_q <= '0;
    end else begin
      if (accept) begin
        tag_q    <= mem_reqTagIn;
        line_q   <= '0;
        cnt      <= '0;
        miss_cnt <= sat_inc(miss_cnt);
      end
      if (beat) begin
        line_q <= line_merged;
        cnt    <= cnt + CNT_WIDTH'(1);
      end
      if (last_beat) begin
        rsp_tag_q  <= tag_q;
        rsp_line_q <= line_merged;
      end
    end
  end

endmodule

// File: tb/tb_ifu_miss_handler.sv
// Bench for ifu_miss_handler.
//   Each scenario task drives stimulus and pushes the expected {tag, line} onto a
//   scoreboard queue. When the response pulse appears, the task pops the entry and
//   compares it inline.
//   Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_ifu_miss_handler;
  localparam int AW = 32;
  localparam int OW = 4;
  localparam int TW = 28;
  localparam int LW = 128;
  localparam int BW = 32;
  localparam int NB = 4;

  logic          Clock = 1'b0;
  logic          Rst;
  logic [TW-1:0] mem_reqTagIn;
  logic          mem_reqTagValidIn;
  logic [TW-1:0] mem_rspTagOut;
  logic [LW-1:0] mem_rspInsLineOut;
  logic          mem_rspInsLineValidOut;
  logic          bus_reqValidOut;
  logic [AW-1:0] bus_reqAddrOut;
  logic          bus_reqReadyIn;
  logic          bus_rspValidIn;
  logic [BW-1:0] bus_rspDataIn;
  logic          busyOut;
  logic [15:0]   missCountOut;

  ifu_miss_handler #(
    .ADDR_WIDTH(AW), .OFFSET_WIDTH(OW), .TAG_WIDTH(TW),
    .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .NUM_BEATS(NB)
  ) dut (
    .Clock(Clock), .Rst(Rst),
    .mem_reqTagIn(mem_reqTagIn), .mem_reqTagValidIn(mem_reqTagValidIn),
    .mem_rspTagOut(mem_rspTagOut), .mem_rspInsLineOut(mem_rspInsLineOut),
    .mem_rspInsLineValidOut(mem_rspInsLineValidOut),
    .bus_reqValidOut(bus_reqValidOut), .bus_reqAddrOut(bus_reqAddrOut),
    .bus_reqReadyIn(bus_reqReadyIn), .bus_rspValidIn(bus_rspValidIn),
    .bus_rspDataIn(bus_rspDataIn), .busyOut(busyOut), .missCountOut(missCountOut)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [LW-1:0] line;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0;
  int            bad = 0;
  int            exp_cnt = 0;
  logic [BW-1:0] beats[NB];
  int            req_bad;
  int            t_start;

  task automatic rand_beats();
    for (int b = 0; b < NB; b++) beats[b] = $urandom;
  endtask

  // Runs one fill from IDLE.
  //   ready_lo   : number of cycles the bus holds ready low.
  //   gap_before : beat index that is preceded by one idle cycle (NB = no gap).
  //   keep_req   : leave the miss input high after the request is issued.
  //   chg_tag    : switch the tag input to 0x0000456 once DATA starts.
  // The task returns on the falling edge where the response pulse is expected.
  // It counts request-phase cycles whose valid or address was wrong in req_bad.
  task automatic drive_fill(input logic [TW-1:0] tag, input int ready_lo,
                            input int gap_before, input bit keep_req, input bit chg_tag);
    exp_t e;
    e = '0;
    e.tag = tag;
    for (int b = 0; b < NB; b++) e.line[b*BW +: BW] = beats[b];
    sbq.push_back(e);
    exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
    req_bad = 0;
    mem_reqTagIn = tag;
    mem_reqTagValidIn = 1'b1;
    t_start = cyc;
    @(negedge Clock);
    if (!keep_req) mem_reqTagValidIn = 1'b0;
    for (int i = 0; i < ready_lo; i++) begin
      bus_reqReadyIn = 1'b0;
      if (bus_reqValidOut !== 1'b1 || bus_reqAddrOut !== {tag, 4'h0}) req_bad++;
      @(negedge Clock);
    end
    if (bus_reqValidOut !== 1'b1 || bus_reqAddrOut !== {tag, 4'h0}) req_bad++;
    bus_reqReadyIn = 1'b1;
    @(negedge Clock);
    bus_reqReadyIn = 1'b0;
    if (chg_tag) mem_reqTagIn = 28'h0000456;
    for (int b = 0; b < NB; b++) begin
      if (b == gap_before) begin
        bus_rspValidIn = 1'b0;
        bus_rspDataIn  = $urandom;
        @(negedge Clock);
      end
      bus_rspValidIn = 1'b1;
      bus_rspDataIn  = beats[b];
      @(negedge Clock);
    end
    bus_rspValidIn = 1'b0;
  endtask

  // Waits up to 20 cycles for the response pulse. It makes no comparison.
  task automatic wait_rsp(output bit got, output int lat);
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      if (mem_rspInsLineValidOut === 1'b1) got = 1;
      else @(negedge Clock);
    end
    lat = cyc - t_start;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    mem_reqTagIn = '0; mem_reqTagValidIn = 1'b0; bus_reqReadyIn = 1'b0;
    bus_rspValidIn = 1'b0; bus_rspDataIn = '0;
    repeat (3) @(negedge Clock);
    Rst = 1'b1;
    @(negedge Clock);
    total++;
    if ({busyOut, bus_reqValidOut, mem_rspInsLineValidOut} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000", {busyOut, bus_reqValidOut, mem_rspInsLineValidOut});
    end
    total++;
    if (bus_reqAddrOut !== '0 || mem_rspTagOut !== '0 || mem_rspInsLineOut !== '0 || missCountOut !== 16'h0) begin
      bad++; $display("FAIL reset_data addr=%h tag=%h line=%h cnt=%h want all 0",
                      bus_reqAddrOut, mem_rspTagOut, mem_rspInsLineOut, missCountOut);
    end
    // A stray bus beat while IDLE must change nothing.
    bus_rspValidIn = 1'b1; bus_rspDataIn = 32'hDEADBEEF;
    @(negedge Clock);
    bus_rspValidIn = 1'b0;
    @(negedge Clock);
    total++;
    if (busyOut !== 1'b0 || mem_rspInsLineValidOut !== 1'b0 || mem_rspInsLineOut !== '0) begin
      bad++; $display("FAIL idle_stray_beat busy=%b vld=%b line=%h want 0/0/0", busyOut, mem_rspInsLineValidOut, mem_rspInsLineOut);
    end
  endtask

  task automatic test_single_fill();
    bit got; int lat; exp_t e;
    beats[0] = 32'h11111111; beats[1] = 32'h22222222;
    beats[2] = 32'h33333333; beats[3] = 32'h44444444;
    drive_fill(28'h0000123, 0, NB, 1'b0, 1'b0);
    wait_rsp(got, lat);
    total++;
    if (req_bad !== 0) begin bad++; $display("FAIL single_req bad_cycles=%0d want 0 (addr 00001230)", req_bad); end
    total++;
    if (!got) begin
      bad++; $display("FAIL single_rsp timeout got=0 want pulse");
    end else begin
      e = sbq.pop_front();
      if (mem_rspTagOut !== e.tag || mem_rspInsLineOut !== e.line || lat !== 6) begin
        bad++; $display("FAIL single_rsp tag=%h line=%h lat=%0d want tag=%h line=%h lat=6",
                        mem_rspTagOut, mem_rspInsLineOut, lat, e.tag, e.line);
      end
    end
    total++;
    if (missCountOut !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", missCountOut); end
    @(negedge Clock);
    total++;
    if (mem_rspInsLineValidOut !== 1'b0 || mem_rspTagOut !== 28'h0000123 ||
        mem_rspInsLineOut !== 128'h44444444_33333333_22222222_11111111) begin
      bad++; $display("FAIL single_hold vld=%b tag=%h line=%h want 0 held", mem_rspInsLineValidOut, mem_rspTagOut, mem_rspInsLineOut);
    end
    @(negedge Clock);
  endtask

  task automatic test_backpressure();
    bit got; int lat; exp_t e;
    rand_beats();
    drive_fill(28'hABCDE01, 3, 2, 1'b0, 1'b0);
    wait_rsp(got, lat);
    total++;
    if (req_bad !== 0) begin bad++; $display("FAIL bp_req_stable bad_cycles=%0d want 0", req_bad); end
    total++;
    if (!got) begin
      bad++; $display("FAIL bp_rsp timeout got=0 want pulse");
    end else begin
      e = sbq.pop_front();
      if (mem_rspTagOut !== e.tag || mem_rspInsLineOut !== e.line || lat !== 10) begin
        bad++; $display("FAIL bp_rsp tag=%h line=%h lat=%0d want tag=%h line=%h lat=10",
                        mem_rspTagOut, mem_rspInsLineOut, lat, e.tag, e.line);
      end
    end
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_cooldown();
    bit got; int lat; exp_t e;
    rand_beats();
    drive_fill(28'h0000123, 0, NB, 1'b1, 1'b0);
    wait_rsp(got, lat);
    total++;
    if (!got) begin
      bad++; $display("FAIL cool_rsp1 timeout got=0 want pulse");
    end else begin
      e = sbq.pop_front();
      if (mem_rspInsLineOut !== e.line || lat !== 6) begin
        bad++; $display("FAIL cool_rsp1 line=%h lat=%0d want line=%h lat=6", mem_rspInsLineOut, lat, e.line);
      end
    end
    @(negedge Clock); // t7: COOL
    total++;
    if (bus_reqValidOut !== 1'b0 || busyOut !== 1'b1) begin
      bad++; $display("FAIL cool_t7 reqv=%b busy=%b want 0/1", bus_reqValidOut, busyOut);
    end
    @(negedge Clock); // t8: IDLE samples the still-high miss
    total++;
    if (bus_reqValidOut !== 1'b0 || busyOut !== 1'b0) begin
      bad++; $display("FAIL cool_t8 reqv=%b busy=%b want 0/0", bus_reqValidOut, busyOut);
    end
    @(negedge Clock); // t9: second request
    mem_reqTagValidIn = 1'b0;
    exp_cnt++;
    total++;
    if (bus_reqValidOut !== 1'b1 || bus_reqAddrOut !== 32'h00001230 || missCountOut !== 16'(exp_cnt)) begin
      bad++; $display("FAIL cool_t9 reqv=%b addr=%h cnt=%0d want 1/00001230/%0d",
                      bus_reqValidOut, bus_reqAddrOut, missCountOut, exp_cnt);
    end
    rand_beats();
    e = '0; e.tag = 28'h0000123;
    for (int b = 0; b < NB; b++) e.line[b*BW +: BW] = beats[b];
    sbq.push_back(e);
    bus_reqReadyIn = 1'b1;
    @(negedge Clock);
    bus_reqReadyIn = 1'b0;
    for (int b = 0; b < NB; b++) begin
      bus_rspValidIn = 1'b1; bus_rspDataIn = beats[b];
      @(negedge Clock);
    end
    bus_rspValidIn = 1'b0;
    wait_rsp(got, lat);
    total++;
    if (!got) begin
      bad++; $display("FAIL cool_rsp2 timeout got=0 want pulse");
    end else begin
      e = sbq.pop_front();
      if (mem_rspTagOut !== e.tag || mem_rspInsLineOut !== e.line) begin
        bad++; $display("FAIL cool_rsp2 tag=%h line=%h want tag=%h line=%h", mem_rspTagOut, mem_rspInsLineOut, e.tag, e.line);
      end
    end
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_tag_change();
    bit got; int lat; exp_t e;
    rand_beats();
    drive_fill(28'h0000123, 0, NB, 1'b0, 1'b1);
    wait_rsp(got, lat);
    total++;
    if (!got) begin
      bad++; $display("FAIL tagchg_rsp timeout got=0 want pulse");
    end else begin
      e = sbq.pop_front();
      if (mem_rspTagOut !== 28'h0000123 || mem_rspInsLineOut !== e.line) begin
        bad++; $display("FAIL tagchg_rsp tag=%h line=%h want tag=0000123 line=%h", mem_rspTagOut, mem_rspInsLineOut, e.line);
      end
    end
    total++;
    if (missCountOut !== 16'(exp_cnt)) begin
      bad++; $display("FAIL tagchg_count got=%0d want=%0d", missCountOut, exp_cnt);
    end
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_reset_mid();
    bit got; int lat; exp_t e; bit stray_bad;
    mem_reqTagIn = 28'h0000789; mem_reqTagValidIn = 1'b1; bus_reqReadyIn = 1'b1;
    @(negedge Clock);
    mem_reqTagValidIn = 1'b0;
    @(negedge Clock);
    bus_reqReadyIn = 1'b0;
    bus_rspValidIn = 1'b1; bus_rspDataIn = 32'hAAAA0000;
    @(negedge Clock);
    bus_rspDataIn = 32'hAAAA0001;
    @(negedge Clock);
    Rst = 1'b0;
    #1;
    total++;
    if ({busyOut, bus_reqValidOut, mem_rspInsLineValidOut} !== 3'b000 || bus_reqAddrOut !== '0 ||
        mem_rspTagOut !== '0 || mem_rspInsLineOut !== '0 || missCountOut !== 16'h0) begin
      bad++; $display("FAIL midreset_outputs busy=%b reqv=%b vld=%b addr=%h tag=%h cnt=%h want all 0",
                      busyOut, bus_reqValidOut, mem_rspInsLineValidOut, bus_reqAddrOut, mem_rspTagOut, missCountOut);
    end
    exp_cnt = 0;
    @(negedge Clock);
    Rst = 1'b1;
    // Stray beats continue after the reset is released.
    stray_bad = 0;
    for (int i = 0; i < 2; i++) begin
      bus_rspValidIn = 1'b1; bus_rspDataIn = 32'hAAAA0002 + 32'(i);
      @(negedge Clock);
      if (busyOut !== 1'b0 || mem_rspInsLineValidOut !== 1'b0) stray_bad = 1;
    end
    bus_rspValidIn = 1'b0;
    total++;
    if (stray_bad) begin bad++; $display("FAIL midreset_stray busy/vld asserted got=1 want=0"); end
    rand_beats();
    drive_fill(28'h0000ACE, 0, 1, 1'b0, 1'b0);
    wait_rsp(got, lat);
    total++;
    if (!got) begin
      bad++; $display("FAIL midreset_refill timeout got=0 want pulse");
    end else begin
      e = sbq.pop_front();
      if (mem_rspTagOut !== e.tag || mem_rspInsLineOut !== e.line || missCountOut !== 16'd1) begin
        bad++; $display("FAIL midreset_refill tag=%h line=%h cnt=%0d want tag=%h line=%h cnt=1",
                        mem_rspTagOut, mem_rspInsLineOut, missCountOut, e.tag, e.line);
      end
    end
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_saturation();
    bit got; int lat; exp_t e;
    force dut.miss_cnt = 16'hFFFE;
    #1;
    release dut.miss_cnt;
    exp_cnt = 65534;
    for (int k = 0; k < 2; k++) begin
      rand_beats();
      drive_fill(28'h0F00000 + 28'(k), 0, NB, 1'b0, 1'b0);
      wait_rsp(got, lat);
      total++;
      if (!got) begin
        bad++; $display("FAIL sat_rsp%0d timeout got=0 want pulse", k);
      end else begin
        e = sbq.pop_front();
        if (mem_rspInsLineOut !== e.line || missCountOut !== 16'hFFFF) begin
          bad++; $display("FAIL sat_rsp%0d line=%h cnt=%h want line=%h cnt=ffff", k, mem_rspInsLineOut, missCountOut, e.line);
        end
      end
      repeat (2) @(negedge Clock);
    end
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_backpressure();
    test_cooldown();
    test_tag_change();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
